// File: rtl/pm_loader_if.sv
// Byte-load, control and instruction-fetch signals between the program-memory
// loader and its host/CPU side.
interface pm_loader_if #(
  parameter int NBITS_O = 11,
  parameter int NBITS_D = 16
);
  logic [7:0]         i_rx_data;
  logic               i_rx_valid;
  logic               i_start;
  logic               i_reload;
  logic [NBITS_O-1:0] i_PmAddr;
  logic [NBITS_D-1:0] o_Instruction;
  logic               o_cpu_rst;
  logic [NBITS_O:0]   o_load_count;
  logic               o_full;
  logic               o_halted;
  logic [1:0]         o_state;

  modport master (
    output i_rx_data, i_rx_valid, i_start, i_reload, i_PmAddr,
    input  o_Instruction, o_cpu_rst, o_load_count, o_full, o_halted, o_state
  );

  modport slave (
    input  i_rx_data, i_rx_valid, i_start, i_reload, i_PmAddr,
    output o_Instruction, o_cpu_rst, o_load_count, o_full, o_halted, o_state
  );
endinterface

// File: rtl/pm_loader.sv
// Program-memory loader: assembles byte pairs into instruction words during
// LOAD, then serves registered instruction fetches to the CPU until HALT.
module pm_loader #(
  parameter int NBITS_O = 11,
  parameter int NBITS_D = 16,
  parameter int OPCODE  = 5
) (
  input  logic          i_clk,
  input  logic          i_reset,
  pm_loader_if.slave    bus
);

  typedef enum logic [1:0] {
    S_LOAD = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_t;

  localparam int               DEPTH      = 1 << NBITS_O;
  localparam logic [NBITS_O:0] FULL_COUNT = (NBITS_O+1)'(DEPTH);

  state_t             state, state_next;
  logic               fetch_valid;
  logic               phase_hi;
  logic [7:0]         lo_byte;
  logic [NBITS_O:0]   load_count;
  logic [NBITS_D-1:0] instr;
  logic               cpu_rst;
  logic               full;
  logic               rx_take;
  logic               wr_en;
  logic               run_stay;

  logic [NBITS_D-1:0] mem [DEPTH];

  assign full     = (load_count == FULL_COUNT);
  assign rx_take  = (state == S_LOAD) && bus.i_rx_valid && !full && !bus.i_reload;
  assign wr_en    = rx_take && phase_hi;
  // Fetches are only honoured while RUN persists, so the output is zero outside RUN.
  assign run_stay = (state == S_RUN) && (state_next == S_RUN);

  always_comb begin
    // NOTE: next state defaults to the current state so no path infers a latch.
    state_next = state;
    if (bus.i_reload) begin
      state_next = S_LOAD;
    end else begin
      case (state)
        S_LOAD: if (bus.i_start) state_next = S_RUN;
        S_RUN:  if (fetch_valid && (instr[NBITS_D-1 -: OPCODE] == '0)) state_next = S_HALT;
        S_HALT: if (bus.i_start) state_next = S_RUN;
        default: state_next = S_LOAD;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= S_LOAD;
      fetch_valid <= 1'b0;
      phase_hi    <= 1'b0;
      lo_byte     <= '0;
      load_count  <= '0;
      instr       <= '0;
      cpu_rst     <= 1'b1;
    end else begin
      state       <= state_next;
      fetch_valid <= run_stay;
      cpu_rst     <= (state_next != S_RUN);
      instr       <= run_stay ? mem[bus.i_PmAddr] : '0;
      if (bus.i_reload) begin
        load_count <= '0;
        phase_hi   <= 1'b0;
      end else if (state == S_LOAD) begin
        if (rx_take) begin
          if (phase_hi) begin
            load_count <= load_count + (NBITS_O+1)'(1);
            phase_hi   <= 1'b0;
          end else begin
            lo_byte  <= bus.i_rx_data;
            phase_hi <= 1'b1;
          end
        end
        // Leaving LOAD drops any unpaired low byte.
        if (bus.i_start) phase_hi <= 1'b0;
      end
    end
  end

  // NOTE: memory has no reset so it maps onto block RAM and survives i_reset.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[load_count[NBITS_O-1:0]] <= NBITS_D'({bus.i_rx_data, lo_byte});
  end

  assign bus.o_Instruction = instr;
  assign bus.o_cpu_rst     = cpu_rst;
  assign bus.o_load_count  = load_count;
  assign bus.o_full        = full;
  assign bus.o_halted      = (state == S_HALT);
  assign bus.o_state       = state;

endmodule
